// File: rtl/reset_sequencer.sv
// reset_sequencer: releases a chain of reset domains one at a time after
// system reset. Each released domain must report ready before the next one
// is released. A domain that stays silent is re-reset up to RETRIES times,
// after which the whole chain is put back in reset and a sticky fault is raised.
module reset_sequencer #(
  parameter int STAGES  = 4,
  parameter int HOLD    = 16,
  parameter int TIMEOUT = 1024,
  parameter int RETRIES = 1,
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic [STAGES-1:0] stage_ready,
  output logic [STAGES-1:0] reset_out,
  output logic              all_released,
  output logic              fault,
  output logic [SW-1:0]     fault_stage
);

  // The longer of the two waits sets the counter width; every compare ends
  // the count before it could wrap.
  localparam int MAXC = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     stage, stage_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [RW-1:0]     retry, retry_nxt;
  logic [STAGES-1:0] reset_out_nxt;
  logic              all_released_nxt;
  logic              fault_nxt;
  logic [SW-1:0]     fault_stage_nxt;

  // State and output registers; reset_in restarts the chain from any state.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state        <= ST_HOLD;
      stage        <= '0;
      count        <= '0;
      retry        <= '0;
      reset_out    <= '1;
      all_released <= 1'b0;
      fault        <= 1'b0;
      fault_stage  <= '0;
    end else begin
      state        <= state_nxt;
      stage        <= stage_nxt;
      count        <= count_nxt;
      retry        <= retry_nxt;
      reset_out    <= reset_out_nxt;
      all_released <= all_released_nxt;
      fault        <= fault_nxt;
      fault_stage  <= fault_stage_nxt;
    end
  end

  // Next-state logic: hold the current stage, wait for its ready, retry or fault.
  always_comb begin
    state_nxt        = state;
    stage_nxt        = stage;
    count_nxt        = count;
    retry_nxt        = retry;
    reset_out_nxt    = reset_out;
    all_released_nxt = all_released;
    fault_nxt        = fault;
    fault_stage_nxt  = fault_stage;

    unique case (state)
      ST_HOLD: begin
        if (count == CW'(HOLD - 1)) begin
          reset_out_nxt[stage] = 1'b0;
          count_nxt            = '0;
          state_nxt            = ST_WAIT;
        end else begin
          count_nxt = count + CW'(1);
        end
      end

      ST_WAIT: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (stage_ready[stage]) begin
          if (stage == SW'(STAGES - 1)) begin
            state_nxt        = ST_RUN;
            all_released_nxt = 1'b1;
          end else begin
            stage_nxt = stage + SW'(1);
            count_nxt = '0;
            retry_nxt = '0;
            state_nxt = ST_HOLD;
          end
        end else if (count == CW'(TIMEOUT - 1)) begin
          if (retry != RW'(RETRIES)) begin
            reset_out_nxt[stage] = 1'b1;
            retry_nxt            = retry + RW'(1);
            count_nxt            = '0;
            state_nxt            = ST_HOLD;
          end else begin
            reset_out_nxt   = '1;
            fault_nxt       = 1'b1;
            fault_stage_nxt = stage;
            state_nxt       = ST_FAULT;
          end
        end else begin
          count_nxt = count + CW'(1);
        end
      end

      ST_RUN: begin
        // Any domain losing ready/lock restarts the whole chain.
        if (!(&stage_ready)) begin
          state_nxt        = ST_HOLD;
          stage_nxt        = '0;
          count_nxt        = '0;
          retry_nxt        = '0;
          reset_out_nxt    = '1;
          all_released_nxt = 1'b0;
          fault_nxt        = 1'b0;
          fault_stage_nxt  = '0;
        end
      end

      ST_FAULT: begin
        // Terminal until reset_in; everything holds.
      end

      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Controller that releases a chain of synchronous reset domains in a fixed order after system reset. It holds every domain in reset and releases them one stage at a time. Each stage waits for that domain's ready or lock indication before the next stage is released. A stage that fails to report ready within a timeout is retried, then flagged as a fault. The block sits between the board-level reset source and the per-domain reset inputs of PLL, memory-controller, peripheral and core logic. It sequences what a single reset timer can only stretch.

## Interface
- STAGES, 4, number of reset domains; legal range 1..32
- HOLD, 16, minimum cycles a stage stays in reset before release; >= 1
- TIMEOUT, 1024, cycles allowed for stage_ready after release; >= 1
- RETRIES, 1, re-reset attempts per stage before fault; >= 0
- clk  in  1  single clock; all logic on rising edge
- reset_in  in  1  synchronous, active-high; restarts the sequence
- stage_ready  in  STAGES  bit i: domain i ready/locked; sampled directly, no synchronizer
- reset_out  out  STAGES  bit i high: domain i held in reset
- all_released  out  1  high while every stage is released and ready
- fault  out  1  sticky; a stage exhausted its retries
- fault_stage  out  SW  index of faulting stage; SW = STAGES>1 ? $clog2(STAGES) : 1

## Operation
- Reset values (edge with reset_in high, from any state): reset_out all ones, all_released 0, fault 0, fault_stage 0, stage 0, count 0, retry 0, state HOLD.
- HOLD: count increments each edge. At the edge where count == HOLD-1:
  - clear reset_out[stage]
  - count := 0
  - go to WAIT
- WAIT, evaluated in priority order:
  - stage_ready[stage] high, stage == STAGES-1: go to RUN, all_released := 1.
  - stage_ready[stage] high, other stage: stage++, count := 0, retry := 0, go to HOLD.
  - Else if count == TIMEOUT-1 and retry < RETRIES: set reset_out[stage], retry++, count := 0, go to HOLD.
  - Else if count == TIMEOUT-1 and retry == RETRIES: reset_out := all ones, fault := 1, fault_stage := stage, go to FAULT.
  - Else count++.
- RUN: if any stage_ready bit is low at an edge, restart the sequence. The restart applies reset values except fault, which stays 0. all_released drops on that same edge.
- FAULT: terminal. stage_ready is ignored. Outputs are held until reset_in.
- Stages above the current index always keep reset_out high. Stages below it are never re-asserted except on a RUN restart or entry to FAULT.
- Counter width is $clog2(max(HOLD,TIMEOUT)+1). Retry width is $clog2(RETRIES+1), minimum 1. No wrap is possible: every compare terminates before overflow.
- If stage_ready and the timeout coincide on the same edge, ready wins.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Edge 0 is the last edge with reset_in sampled high, or the RUN-restart edge.
- With all stage_ready held high:
  - reset_out[i] falls at edge (i+1)*HOLD + i.
  - all_released rises at edge STAGES*HOLD + STAGES.
- If WAIT is entered at edge w with ready low:
  - timeout acts at edge w+TIMEOUT.
  - the re-released stage falls again at edge w+TIMEOUT+HOLD.
- reset_in asserted mid-sequence: reset values appear after that edge and the sequence timing restarts from edge 0.
- RUN restart: reset_out goes all ones one edge after the dropping stage_ready is sampled.

## Test plan
All scenarios use STAGES=3, HOLD=4, TIMEOUT=8, RETRIES=1, with edges counted from edge 0.
- **All ready tied high.** Required response:
  - reset_out 111 until edge 4, 110 at edge 4, 100 at edge 9, 000 at edge 14
  - all_released 1 at edge 15
  - fault 0 throughout
- **stage_ready[1] held low.** Required response:
  - reset_out[1] falls at 9, re-asserts at 17, falls at 21
  - at edge 29: fault=1, fault_stage=1, reset_out=111
  - a later stage_ready change does not alter any output
- **stage_ready[1] rises exactly at edge 17, the timeout edge.** Required response: the stage advances with no retry, reset_out[2] falls at 21, and all_released rises at 22.
- **Reach RUN, then pulse stage_ready[0] low for one cycle.** Required response:
  - next edge: reset_out=111, all_released=0
  - the full scenario-1 timing repeats from that edge
- **reset_in high for one cycle during stage-1 WAIT.** Required response: outputs return to reset values, then scenario-1 timing repeats from the release.
- **STAGES=1, HOLD=1, ready high.** Required response: reset_out falls at edge 1, all_released rises at edge 2, and the 1-bit fault_stage stays 0.
